rect_painter: RTL and testbench
===============================

RECT_PAINTER -- requirements
Module: rect_painter

Interface
REQ-001 The block SHALL use exactly one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-002 Parameter H_LEN, default 200, SHALL set the framebuffer width in pixels.
REQ-003 Parameter V_LEN, default 150, SHALL set the framebuffer height in pixels.
REQ-004 Parameter AW, default 15, SHALL set the write-address width.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_x  in  8  left column
- cmd_y  in  8  top row
- cmd_w  in  8  width
- cmd_h  in  8  height
- cmd_color  in  12  RGB444 fill value
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- we  out  1  framebuffer write enable
- addr  out  AW  framebuffer write address
- wdata  out  12  framebuffer write data

Function
REQ-006 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; all cmd_* fields SHALL be captured on that edge.
REQ-007 The FSM SHALL have the states IDLE, CLIP, DRAW and DONE.
- cmd_ready SHALL be 1 only in IDLE.
- busy SHALL be 1 in CLIP, DRAW and DONE.
REQ-008 Transitions:
- IDLE->CLIP on accept.
- CLIP->DRAW when the clipped area is non-empty, otherwise CLIP->DONE.
- DRAW->DONE after the last pixel.
- DONE->IDLE unconditionally.
REQ-009 In CLIP, the block SHALL compute x_end=min(cmd_x+cmd_w, H_LEN) and y_end=min(cmd_y+cmd_h, V_LEN) using 9-bit sums, so no wrap-around can occur.
REQ-010 The clipped area SHALL be empty when cmd_w=0, cmd_h=0, cmd_x>=H_LEN or cmd_y>=V_LEN.
REQ-011 DRAW SHALL write one pixel per cycle in row-major order, from (cmd_x,cmd_y) to (x_end-1,y_end-1).
- Each write SHALL drive we=1, addr=row*H_LEN+col and wdata=cmd_color.
REQ-012 The row base address SHALL advance by H_LEN per row with an adder; no multiplier SHALL be used.
REQ-013 we, addr, wdata and done SHALL be registered outputs.
- When we=0, addr and wdata SHALL hold their last values.
REQ-014 Latency: for a command accepted at edge T with N clipped pixels:
- writes SHALL occur in cycles T+2 through T+1+N;
- done SHALL be 1 in cycle T+2+N;
- for N=0, done SHALL be 1 in cycle T+2.
REQ-015 done SHALL be high for exactly one cycle per accepted command.
REQ-016 Any cmd_valid asserted while busy=1 SHALL be ignored; the command is accepted only once the block returns to IDLE.
REQ-017 addr SHALL never exceed H_LEN*V_LEN-1 (29999 at default parameters).

Reset
REQ-018 While rstn=0, the block SHALL be in IDLE with cmd_ready=1, busy=0, done=0, we=0, addr=0 and wdata=0.
REQ-019 Reset asserted mid-DRAW SHALL abort the command immediately.
- No further writes SHALL occur.
- No done pulse SHALL be generated for the aborted command.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enum;
- the H_LEN and V_LEN defaults;
- the RGB444 pixel type.
REQ-021 One sub-module, pix_scan, SHALL hold the column/row counters and the row-base adder; the FSM and clipping SHALL live in rect_painter.

Verification
REQ-022 Command (0,0,2,2,0xF00): writes SHALL occur at addr 0, 1, 200, 201 with wdata=0xF00, and done SHALL be high 6 cycles after accept.
REQ-023 Command (198,149,5,5,0x0F0): only addr 29998 and 29999 SHALL be written, and done SHALL be high at T+4.
REQ-024 Command (10,10,0,7,0x00F): no write SHALL occur, and done SHALL be high at T+2.
REQ-025 Command (0,0,200,150,0xFFF): exactly 30000 writes SHALL occur, the last at addr 29999, and done SHALL be high at T+30002.
REQ-026 cmd_valid held high across two back-to-back commands:
- the second SHALL be accepted in the cycle after done (while the FSM is in IDLE);
- cmd_ready SHALL be 0 throughout busy.
REQ-027 rstn pulsed low after the 3rd write of a 4x4 command:
- we SHALL be 0 from reset assertion onward;
- no done pulse SHALL occur;
- cmd_ready SHALL be 1 after release.

Source files
------------

// File: rtl/rect_painter_pkg.sv
// Shared types and defaults for the rectangle fill engine.
package rect_painter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLIP,
        ST_DRAW,
        ST_DONE
    } state_t;

    localparam int H_LEN_DEF = 200;
    localparam int V_LEN_DEF = 150;

    typedef logic [11:0] rgb444_t;

    // Exclusive end coordinate; the 9-bit sum makes wrap-around impossible.
    function automatic logic [8:0] clip_end(input logic [7:0] start,
                                            input logic [7:0] len,
                                            input logic [8:0] lim);
        logic [8:0] sum;
        sum = {1'b0, start} + {1'b0, len};
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/rect_painter_pix_scan.sv
// Row-major pixel walker: column/row counters and a row-base address that
// advances by one line width per row.
module pix_scan
    import rect_painter_pkg::*;
#(
    parameter int H_LEN = H_LEN_DEF,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic          step,
    input  logic [7:0]    x_start,
    input  logic [7:0]    y_start,
    input  logic [AW-1:0] base_start,
    input  logic [8:0]    x_end,
    input  logic [8:0]    y_end,
    output logic [7:0]    col,
    output logic [7:0]    row,
    output logic [AW-1:0] base,
    output logic          last
);

    logic col_last;
    logic row_last;

    assign col_last = ({1'b0, col} + 9'd1) == x_end;
    assign row_last = ({1'b0, row} + 9'd1) == y_end;
    assign last     = col_last && row_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (load) begin
            col  <= x_start;
            row  <= y_start;
            base <= base_start;
        end else if (step) begin
            if (col_last) begin
                col  <= x_start;
                row  <= row + 8'd1;
                base <= base + AW'(H_LEN);
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/rect_painter.sv
// Rectangle fill engine: accepts a clipped rectangle command and streams one
// framebuffer write per cycle in row-major order, then pulses done.
module rect_painter
    import rect_painter_pkg::*;
#(
    parameter int H_LEN = H_LEN_DEF,
    parameter int V_LEN = V_LEN_DEF,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic [7:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [11:0]   cmd_color,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [11:0]   wdata
);

    state_t        state;
    logic [7:0]    cx, cy, cw, ch;
    rgb444_t       color;
    logic [8:0]    x_end, y_end;
    logic          empty;
    logic [AW-1:0] base_start;
    logic [7:0]    col, row;
    logic [AW-1:0] base;
    logic          last;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    assign x_end = clip_end(cx, cw, 9'(H_LEN));
    assign y_end = clip_end(cy, ch, 9'(V_LEN));
    assign empty = (cw == 8'd0) || (ch == 8'd0) ||
                   ({1'b0, cx} >= 9'(H_LEN)) || ({1'b0, cy} >= 9'(V_LEN));

    // Start-row base as a constant shift-and-add over the set bits of H_LEN.
    always_comb begin
        base_start = '0;
        for (int i = 0; i < 9; i++) begin
            if (H_LEN[i])
                base_start = base_start + (AW'(cy) << i);
        end
    end

    pix_scan #(.H_LEN(H_LEN), .AW(AW)) u_scan (
        .clk        (clk),
        .rstn       (rstn),
        .load       (state == ST_CLIP),
        .step       (state == ST_DRAW),
        .x_start    (cx),
        .y_start    (cy),
        .base_start (base_start),
        .x_end      (x_end),
        .y_end      (y_end),
        .col        (col),
        .row        (row),
        .base       (base),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cx    <= '0;
            cy    <= '0;
            cw    <= '0;
            ch    <= '0;
            color <= '0;
            we    <= 1'b0;
            done  <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cx    <= cmd_x;
                        cy    <= cmd_y;
                        cw    <= cmd_w;
                        ch    <= cmd_h;
                        color <= cmd_color;
                        state <= ST_CLIP;
                    end
                end
                ST_CLIP: state <= empty ? ST_DONE : ST_DRAW;
                ST_DRAW: begin
                    we    <= 1'b1;
                    addr  <= base + {{(AW-8){1'b0}}, col};
                    wdata <= color;
                    if (last)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_painter.sv
// Directed bench for rect_painter: cycle model of the command timeline plus
// hand-computed expectations for the reference rectangles.
module tb_rect_painter;

    localparam int H = 200;
    localparam int V = 150;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic        busy, done, we;
    logic [14:0] addr;
    logic [11:0] wdata;

    rect_painter dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .busy(busy), .done(done), .we(we),
        .addr(addr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a per-cycle schedule of expected outputs built at each accept.
    typedef struct {
        bit busy;
        bit we;
        bit done;
        int addr;
        int data;
    } ent_t;

    ent_t q[$];
    bit   e_busy = 0, e_we = 0, e_done = 0;
    int   e_addr = 0, e_data = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_cyc = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            e_busy = 0; e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
        end else begin
            bit   rdy;
            ent_t ent;
            cyc++;
            rdy = !e_busy;
            if (q.size() > 0) begin
                ent = q.pop_front();
                e_busy = ent.busy; e_we = ent.we; e_done = ent.done;
                if (ent.we) begin
                    e_addr = ent.addr;
                    e_data = ent.data;
                end
            end else begin
                e_busy = 0; e_we = 0; e_done = 0;
            end
            if (rdy && cmd_valid) begin
                int x, y, xe, ye;
                x = int'(cmd_x); y = int'(cmd_y);
                xe = (x + int'(cmd_w) < H) ? x + int'(cmd_w) : H;
                ye = (y + int'(cmd_h) < V) ? y + int'(cmd_h) : V;
                acc_cnt++;
                acc_cyc = cyc;
                e_busy = 1;
                q.push_back('{busy: 1, we: 0, done: 0, addr: 0, data: 0});
                for (int r = y; r < ye; r++)
                    for (int c = x; c < xe; c++)
                        q.push_back('{busy: 1, we: 1, done: 0, addr: r * H + c,
                                      data: int'(cmd_color)});
                q.push_back('{busy: 0, we: 0, done: 1, addr: 0, data: 0});
            end
        end
    end

    // Compare process and write/done log.
    int log_addr[$];
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        check("cmd_ready", int'(cmd_ready), int'(!e_busy));
        check("busy", int'(busy), int'(e_busy));
        check("we", int'(we), int'(e_we));
        check("done", int'(done), int'(e_done));
        check("addr", int'(addr), e_addr);
        check("wdata", int'(wdata), e_data);
        if (we) log_addr.push_back(int'(addr));
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic send(input int x, input int y, input int w, input int h,
                        input int c, input int budget);
        int a0, d0;
        bit ok;
        @(negedge clk);
        cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h);
        cmd_color = 12'(c);
        a0 = acc_cnt;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) ok = 1;
        end
        check("accept_timeout", int'(ok), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) ok = 1;
        end
        check("done_timeout", int'(ok), 1);
    endtask

    initial begin
        int e1[4];
        int e5[4];
        int a0, t1, d0;
        bit ok;
        e1 = '{0, 1, 200, 201};
        e5 = '{1005, 1006, 1407, 1607};

        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_we", int'(we), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_wdata", int'(wdata), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 2x2 at origin
        log_addr.delete();
        send(0, 0, 2, 2, 'hF00, 20);
        check("t1_nwrites", log_addr.size(), 4);
        if (log_addr.size() == 4)
            for (int i = 0; i < 4; i++) check("t1_addr", log_addr[i], e1[i]);
        check("t1_done_lat", done_cyc - acc_cyc, 6);

        // clipped bottom-right corner
        log_addr.delete();
        send(198, 149, 5, 5, 'h0F0, 20);
        check("t2_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t2_addr0", log_addr[0], 29998);
            check("t2_addr1", log_addr[1], 29999);
        end
        check("t2_done_lat", done_cyc - acc_cyc, 4);

        // zero width
        log_addr.delete();
        send(10, 10, 0, 7, 'h00F, 20);
        check("t3_nwrites", log_addr.size(), 0);
        check("t3_done_lat", done_cyc - acc_cyc, 2);

        // off-screen origin
        log_addr.delete();
        send(200, 3, 4, 4, 'h321, 20);
        check("t3b_nwrites", log_addr.size(), 0);
        check("t3b_done_lat", done_cyc - acc_cyc, 2);

        // full screen
        log_addr.delete();
        send(0, 0, 200, 150, 'hFFF, 30100);
        check("t4_nwrites", log_addr.size(), 30000);
        if (log_addr.size() > 0) check("t4_last_addr", log_addr[$], 29999);
        check("t4_done_lat", done_cyc - acc_cyc, 30002);

        // back-to-back with cmd_valid held high
        log_addr.delete();
        @(negedge clk);
        cmd_x = 8'd5; cmd_y = 8'd5; cmd_w = 8'd2; cmd_h = 8'd1; cmd_color = 12'h123;
        a0 = acc_cnt;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) ok = 1;
        end
        check("t5_accept1", int'(ok), 1);
        t1 = acc_cyc;
        cmd_x = 8'd7; cmd_y = 8'd7; cmd_w = 8'd1; cmd_h = 8'd2; cmd_color = 12'h456;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_cnt == a0 + 2) ok = 1;
        end
        check("t5_accept2", int'(ok), 1);
        check("t5_accept_gap", acc_cyc - t1, 5);
        check("t5_done1_cyc", done_cyc - t1, 4);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (done_cnt == d0 + 2) ok = 1;
        end
        check("t5_done2", int'(ok), 1);
        check("t5_nwrites", log_addr.size(), 4);
        if (log_addr.size() == 4)
            for (int i = 0; i < 4; i++) check("t5_addr", log_addr[i], e5[i]);

        // reset after the third write of a 4x4 fill
        log_addr.delete();
        d0 = done_cnt;
        @(negedge clk);
        cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd4; cmd_h = 8'd4; cmd_color = 12'hAAA;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (log_addr.size() == 3) ok = 1;
        end
        check("t6_third_write", int'(ok), 1);
        rstn = 1'b0;
        #1;
        check("t6_we_in_rst", int'(we), 0);
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("t6_nwrites", log_addr.size(), 3);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_ready", int'(cmd_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
